pipe_control_unit: RTL and testbench
====================================

// Module: pipe_control_unit
// PURPOSE
//  Decode-stage controller driving data_path_TOP: consumes op_code, control_unit_funct, eq_ne; produces the
//  control word the data path consumes. Tracks the iterative multiplier with a busy FSM and stalls decode on
//  HI/LO hazards. Flags illegal instructions. Sits beside data_path_TOP in the processor top.
// PARAMETERS
//  MULT_LAT  32  cycles from start_mult pulse until HI/LO are valid (range 2..63)
// PORTS
//  clk                 in   1  rising-edge clock
//  reset               in   1  synchronous, active-high
//  op_code             in   6  instr_d[31:26] from data path
//  control_unit_funct  in   6  instr_d[5:0] from data path
//  eq_ne               in   1  1 = decode-stage register operands equal
//  regwrite_d          out  1  register write enable
//  regdst_d            out  1  1 = rd destination, 0 = rt
//  alusrc_d            out  1  1 = immediate operand
//  aluctrl_d           out  4  ALU op: AND 0000 OR 0001 XOR 0010 NOR 0011 ADD 0100 SUB 0101 SLT 0110 SLTU 0111 LUI 1000
//  memwrite_d          out  1  store enable
//  memtoreg_d          out  1  1 = writeback from memory
//  se_ze               out  1  1 = sign-extend, 0 = zero-extend immediate
//  outselect_d         out  2  00 ALU, 01 HI, 10 LO
//  start_mult          out  1  one-cycle multiplier launch pulse
//  mult_sign           out  1  1 = signed (MULT), 0 = MULTU
//  output_branch       out  1  1 = instruction is BEQ/BNE
//  pcsrc               out  2  00 PC+4, 01 branch target, 10 jump target
//  stall_d             out  1  hold fetch/decode, insert bubble
//  mult_busy           out  1  multiplier in flight
//  illegal_instr       out  1  sticky: unsupported encoding decoded
// BEHAVIOUR
//  Decode (combinational from op_code/funct/eq_ne/state), 0-cycle latency:
//   R-type (op 000000): regwrite=1 regdst=1; funct ADD 100000/ADDU 100001->0100, SUB 100010/SUBU 100011->0101,
//     AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010, SLTU 101011 per aluctrl table.
//     MFHI 010000 / MFLO 010010: regwrite=1 regdst=1 outselect 01/10. MULT 011000 / MULTU 011001: regwrite=0,
//     start_mult per FSM, mult_sign 1/0. funct 000000 (NOP/SLL 0) -> all-zero word, not illegal.
//   I-type: ADDI 001000/ADDIU 001001 (ADD,se=1), SLTI 001010 (SLT,se=1), SLTIU 001011 (SLTU,se=1),
//     ANDI 001100/ORI 001101/XORI 001110 (se=0), LUI 001111 (LUI); all regwrite=1 alusrc=1 regdst=0.
//   LW 100011: regwrite alusrc memtoreg se=1 ADD. SW 101011: memwrite alusrc se=1 ADD.
//   BEQ 000100 / BNE 000101: output_branch=1, SUB, se=1; pcsrc=01 iff (BEQ&eq_ne)|(BNE&~eq_ne), else 00.
//   J 000010: pcsrc=10, all enables 0.
//   Any other op/funct: bubble word (all 0), illegal_instr set on next edge; cleared only by reset.
//  Multiplier FSM (registered): states IDLE, BUSY; 6-bit down-counter cnt.
//   IDLE + MULT/MULTU decoded: start_mult=1 this cycle; next edge -> BUSY, cnt=MULT_LAT-1.
//   BUSY: cnt decrements each edge; at cnt==0 edge -> IDLE. mult_busy=1 in BUSY only.
//   BUSY + MULT/MULTU/MFHI/MFLO decoded: stall_d=1, word forced to bubble (regwrite, memwrite, start_mult,
//     output_branch = 0, pcsrc=00); instruction re-decoded on the cycle FSM reaches IDLE.
//   BUSY + any other instruction: decoded normally, no stall.
//  Bubble has priority over branch: stalled instruction never redirects PC.
//  Reset (sync): state=IDLE, cnt=0, illegal_instr=0; while reset=1 all outputs 0 regardless of inputs.
//   Reset during BUSY abandons the multiply; next MULT after reset starts immediately.
//  Back-to-back MULT: second stalls MULT_LAT cycles, then pulses start_mult exactly once.
// TESTING
//  reset=1 with op=000000 funct=100000 -> every output 0; release -> word 17'b11001000000000000 (ADD).
//  op=000100, eq_ne=1 -> pcsrc=01 output_branch=1; eq_ne=0 -> pcsrc=00; op=000101 eq_ne=0 -> pcsrc=01.
//  MULT then MFLO held (MULT_LAT=4) -> start_mult 1 cycle, stall_d=1 for 4 cycles, then outselect=10 regwrite=1.
//  MULT, reset at 2nd BUSY cycle, MULTU -> mult_busy drops, start_mult=1 mult_sign=0 first cycle after reset.
//  op=111111 -> bubble word, illegal_instr=1 next cycle, stays 1 through ADD until reset.
//  BUSY + LW (op 100011) -> no stall, regwrite alusrc memtoreg se_ze=1 aluctrl=0100.

Source files
------------

// File: rtl/pipe_control_unit.sv
// pipe_control_unit
// Decode-stage controller for data_path_TOP. Turns op_code/funct/eq_ne into the
// control word, launches the iterative multiplier, stalls decode on HI/LO
// hazards while the multiplier is in flight, and latches a sticky
// illegal-instruction flag.
module pipe_control_unit #(
  parameter int MULT_LAT = 32  // cycles from start_mult until HI/LO are valid (2..63)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op_code,
  input  logic [5:0] control_unit_funct,
  input  logic       eq_ne,
  output logic       regwrite_d,
  output logic       regdst_d,
  output logic       alusrc_d,
  output logic [3:0] aluctrl_d,
  output logic       memwrite_d,
  output logic       memtoreg_d,
  output logic       se_ze,
  output logic [1:0] outselect_d,
  output logic       start_mult,
  output logic       mult_sign,
  output logic       output_branch,
  output logic [1:0] pcsrc,
  output logic       stall_d,
  output logic       mult_busy,
  output logic       illegal_instr
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes
  localparam logic [5:0] FN_NOP   = 6'b000000;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  // ALU operation codes
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_NOR  = 4'b0011;
  localparam logic [3:0] ALU_ADD  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_LUI  = 4'b1000;

  // Counter reload: BUSY lasts exactly MULT_LAT cycles (cnt MULT_LAT-1 down to 0)
  localparam logic [5:0] CNT_LOAD = 6'(MULT_LAT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state_reg, state_next;
  logic [5:0] cnt_reg, cnt_next;
  logic       illegal_reg;

  // Raw decode results, before stall/reset masking
  logic       dec_regwrite, dec_regdst, dec_alusrc;
  logic [3:0] dec_aluctrl;
  logic       dec_memwrite, dec_memtoreg, dec_se_ze;
  logic [1:0] dec_outselect;
  logic       dec_mult_sign, dec_branch;
  logic [1:0] dec_pcsrc;
  logic       dec_is_mult, dec_is_mfhilo, dec_illegal;
  logic       hazard;

  // Instruction decode: pure function of op_code/funct/eq_ne
  always_comb begin
    dec_regwrite  = 1'b0;
    dec_regdst    = 1'b0;
    dec_alusrc    = 1'b0;
    dec_aluctrl   = ALU_AND;
    dec_memwrite  = 1'b0;
    dec_memtoreg  = 1'b0;
    dec_se_ze     = 1'b0;
    dec_outselect = 2'b00;
    dec_mult_sign = 1'b0;
    dec_branch    = 1'b0;
    dec_pcsrc     = 2'b00;
    dec_is_mult   = 1'b0;
    dec_is_mfhilo = 1'b0;
    dec_illegal   = 1'b0;
    case (op_code)
      OP_RTYPE: begin
        case (control_unit_funct)
          FN_ADD, FN_ADDU: begin dec_regwrite = 1'b1; dec_regdst = 1'b1; dec_aluctrl = ALU_ADD;  end
          FN_SUB, FN_SUBU: begin dec_regwrite = 1'b1; dec_regdst = 1'b1; dec_aluctrl = ALU_SUB;  end
          FN_AND:          begin dec_regwrite = 1'b1; dec_regdst = 1'b1; dec_aluctrl = ALU_AND;  end
          FN_OR:           begin dec_regwrite = 1'b1; dec_regdst = 1'b1; dec_aluctrl = ALU_OR;   end
          FN_XOR:          begin dec_regwrite = 1'b1; dec_regdst = 1'b1; dec_aluctrl = ALU_XOR;  end
          FN_NOR:          begin dec_regwrite = 1'b1; dec_regdst = 1'b1; dec_aluctrl = ALU_NOR;  end
          FN_SLT:          begin dec_regwrite = 1'b1; dec_regdst = 1'b1; dec_aluctrl = ALU_SLT;  end
          FN_SLTU:         begin dec_regwrite = 1'b1; dec_regdst = 1'b1; dec_aluctrl = ALU_SLTU; end
          FN_MFHI: begin
            dec_regwrite  = 1'b1;
            dec_regdst    = 1'b1;
            dec_outselect = 2'b01;
            dec_is_mfhilo = 1'b1;
          end
          FN_MFLO: begin
            dec_regwrite  = 1'b1;
            dec_regdst    = 1'b1;
            dec_outselect = 2'b10;
            dec_is_mfhilo = 1'b1;
          end
          FN_MULT: begin
            dec_is_mult   = 1'b1;
            dec_mult_sign = 1'b1;
          end
          FN_MULTU: begin
            dec_is_mult   = 1'b1;
            dec_mult_sign = 1'b0;
          end
          FN_NOP: ;  // NOP / SLL 0: legal all-zero word
          default: dec_illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin dec_regwrite = 1'b1; dec_alusrc = 1'b1; dec_aluctrl = ALU_ADD;  dec_se_ze = 1'b1; end
      OP_SLTI:           begin dec_regwrite = 1'b1; dec_alusrc = 1'b1; dec_aluctrl = ALU_SLT;  dec_se_ze = 1'b1; end
      OP_SLTIU:          begin dec_regwrite = 1'b1; dec_alusrc = 1'b1; dec_aluctrl = ALU_SLTU; dec_se_ze = 1'b1; end
      OP_ANDI:           begin dec_regwrite = 1'b1; dec_alusrc = 1'b1; dec_aluctrl = ALU_AND;  end
      OP_ORI:            begin dec_regwrite = 1'b1; dec_alusrc = 1'b1; dec_aluctrl = ALU_OR;   end
      OP_XORI:           begin dec_regwrite = 1'b1; dec_alusrc = 1'b1; dec_aluctrl = ALU_XOR;  end
      OP_LUI:            begin dec_regwrite = 1'b1; dec_alusrc = 1'b1; dec_aluctrl = ALU_LUI;  end
      OP_LW: begin
        dec_regwrite = 1'b1;
        dec_alusrc   = 1'b1;
        dec_memtoreg = 1'b1;
        dec_se_ze    = 1'b1;
        dec_aluctrl  = ALU_ADD;
      end
      OP_SW: begin
        dec_memwrite = 1'b1;
        dec_alusrc   = 1'b1;
        dec_se_ze    = 1'b1;
        dec_aluctrl  = ALU_ADD;
      end
      OP_BEQ: begin
        dec_branch  = 1'b1;
        dec_aluctrl = ALU_SUB;
        dec_se_ze   = 1'b1;
        dec_pcsrc   = eq_ne ? 2'b01 : 2'b00;
      end
      OP_BNE: begin
        dec_branch  = 1'b1;
        dec_aluctrl = ALU_SUB;
        dec_se_ze   = 1'b1;
        dec_pcsrc   = eq_ne ? 2'b00 : 2'b01;
      end
      OP_J: dec_pcsrc = 2'b10;
      default: dec_illegal = 1'b1;
    endcase
  end

  // HI/LO hazard: anything touching the multiplier waits until it is idle
  assign hazard = (state_reg == BUSY) && (dec_is_mult || dec_is_mfhilo);

  // Output word: reset forces zero, a hazard forces a bubble, otherwise pass decode
  always_comb begin
    regwrite_d    = 1'b0;
    regdst_d      = 1'b0;
    alusrc_d      = 1'b0;
    aluctrl_d     = 4'b0000;
    memwrite_d    = 1'b0;
    memtoreg_d    = 1'b0;
    se_ze         = 1'b0;
    outselect_d   = 2'b00;
    start_mult    = 1'b0;
    mult_sign     = 1'b0;
    output_branch = 1'b0;
    pcsrc         = 2'b00;
    stall_d       = 1'b0;
    mult_busy     = 1'b0;
    illegal_instr = 1'b0;
    if (!reset) begin
      mult_busy     = (state_reg == BUSY);
      illegal_instr = illegal_reg;
      if (hazard) begin
        stall_d = 1'b1;
      end else begin
        regwrite_d    = dec_regwrite;
        regdst_d      = dec_regdst;
        alusrc_d      = dec_alusrc;
        aluctrl_d     = dec_aluctrl;
        memwrite_d    = dec_memwrite;
        memtoreg_d    = dec_memtoreg;
        se_ze         = dec_se_ze;
        outselect_d   = dec_outselect;
        start_mult    = dec_is_mult;  // hazard is clear, so FSM is IDLE here
        mult_sign     = dec_mult_sign;
        output_branch = dec_branch;
        pcsrc         = dec_pcsrc;
      end
    end
  end

  // Multiplier FSM next-state: launch from IDLE, count down MULT_LAT cycles in BUSY
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (dec_is_mult) begin
          state_next = BUSY;
          cnt_next   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt_reg == 6'd0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - 6'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 6'd0;
      end
    endcase
  end

  // State, counter and sticky illegal flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= 6'd0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (dec_illegal) begin
        illegal_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_control_unit.sv
// tb_pipe_control_unit
// Directed vectors with hand-computed control words for pipe_control_unit
// (MULT_LAT = 4). Word order: regwrite regdst alusrc aluctrl[3:0] memwrite
// memtoreg se_ze outselect[1:0] start_mult mult_sign output_branch pcsrc[1:0].
module tb_pipe_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op_code;
  logic [5:0] control_unit_funct;
  logic       eq_ne;
  logic       regwrite_d, regdst_d, alusrc_d;
  logic [3:0] aluctrl_d;
  logic       memwrite_d, memtoreg_d, se_ze;
  logic [1:0] outselect_d;
  logic       start_mult, mult_sign, output_branch;
  logic [1:0] pcsrc;
  logic       stall_d, mult_busy, illegal_instr;

  int checks = 0;
  int errors = 0;

  logic [16:0] word;
  assign word = {regwrite_d, regdst_d, alusrc_d, aluctrl_d, memwrite_d, memtoreg_d,
                 se_ze, outselect_d, start_mult, mult_sign, output_branch, pcsrc};

  pipe_control_unit #(.MULT_LAT(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .op_code            (op_code),
    .control_unit_funct (control_unit_funct),
    .eq_ne              (eq_ne),
    .regwrite_d         (regwrite_d),
    .regdst_d           (regdst_d),
    .alusrc_d           (alusrc_d),
    .aluctrl_d          (aluctrl_d),
    .memwrite_d         (memwrite_d),
    .memtoreg_d         (memtoreg_d),
    .se_ze              (se_ze),
    .outselect_d        (outselect_d),
    .start_mult         (start_mult),
    .mult_sign          (mult_sign),
    .output_branch      (output_branch),
    .pcsrc              (pcsrc),
    .stall_d            (stall_d),
    .mult_busy          (mult_busy),
    .illegal_instr      (illegal_instr)
  );

  always #5 clk = ~clk;

  // Expected control words
  localparam logic [16:0] W_ZERO = 17'b0;
  localparam logic [16:0] W_ADD  = 17'b1_1_0_0100_0_0_0_00_0_0_0_00;
  localparam logic [16:0] W_SUB  = 17'b1_1_0_0101_0_0_0_00_0_0_0_00;
  localparam logic [16:0] W_SLTU = 17'b1_1_0_0111_0_0_0_00_0_0_0_00;
  localparam logic [16:0] W_ORI  = 17'b1_0_1_0001_0_0_0_00_0_0_0_00;
  localparam logic [16:0] W_ADDI = 17'b1_0_1_0100_0_0_1_00_0_0_0_00;
  localparam logic [16:0] W_LW   = 17'b1_0_1_0100_0_1_1_00_0_0_0_00;
  localparam logic [16:0] W_SW   = 17'b0_0_1_0100_1_0_1_00_0_0_0_00;
  localparam logic [16:0] W_BR_T = 17'b0_0_0_0101_0_0_1_00_0_0_1_01;
  localparam logic [16:0] W_BR_N = 17'b0_0_0_0101_0_0_1_00_0_0_1_00;
  localparam logic [16:0] W_J    = 17'b0_0_0_0000_0_0_0_00_0_0_0_10;
  localparam logic [16:0] W_MFHI = 17'b1_1_0_0000_0_0_0_01_0_0_0_00;
  localparam logic [16:0] W_MFLO = 17'b1_1_0_0000_0_0_0_10_0_0_0_00;
  localparam logic [16:0] W_MULT = 17'b0_0_0_0000_0_0_0_00_1_1_0_00;
  localparam logic [16:0] W_MULU = 17'b0_0_0_0000_0_0_0_00_1_0_0_00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s = %h", tag, obs);
    end
  endtask

  // Advance one clock and land 1 time unit past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply an instruction and let the combinational decode settle
  task automatic apply(input logic [5:0] op, input logic [5:0] fn, input logic eq);
    op_code            = op;
    control_unit_funct = fn;
    eq_ne              = eq;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    apply(6'b000000, 6'b100000, 1'b0);
    tick();
    check("rst_word",    32'(word), 32'(W_ZERO));
    check("rst_stall",   32'(stall_d), 32'd0);
    check("rst_busy",    32'(mult_busy), 32'd0);
    check("rst_illegal", 32'(illegal_instr), 32'd0);

    reset = 1'b0;
    #1;
    check("add_word", 32'(word), 32'(W_ADD));
    apply(6'b000000, 6'b100011, 1'b0); check("subu_word", 32'(word), 32'(W_SUB));
    apply(6'b000000, 6'b101011, 1'b0); check("sltu_word", 32'(word), 32'(W_SLTU));
    apply(6'b001101, 6'b000000, 1'b0); check("ori_word",  32'(word), 32'(W_ORI));
    apply(6'b001000, 6'b000000, 1'b0); check("addi_word", 32'(word), 32'(W_ADDI));
    apply(6'b001111, 6'b000000, 1'b0); check("lui_alu",   32'(aluctrl_d), 32'h8);
    apply(6'b100011, 6'b000000, 1'b0); check("lw_word",   32'(word), 32'(W_LW));
    apply(6'b101011, 6'b000000, 1'b0); check("sw_word",   32'(word), 32'(W_SW));
    apply(6'b000100, 6'b000000, 1'b1); check("beq_taken", 32'(word), 32'(W_BR_T));
    apply(6'b000100, 6'b000000, 1'b0); check("beq_not",   32'(word), 32'(W_BR_N));
    apply(6'b000101, 6'b000000, 1'b0); check("bne_taken", 32'(word), 32'(W_BR_T));
    apply(6'b000101, 6'b000000, 1'b1); check("bne_not",   32'(word), 32'(W_BR_N));
    apply(6'b000010, 6'b000000, 1'b0); check("j_word",    32'(word), 32'(W_J));
    apply(6'b000000, 6'b010000, 1'b0); check("mfhi_word", 32'(word), 32'(W_MFHI));
    apply(6'b000000, 6'b000000, 1'b0); check("nop_word",  32'(word), 32'(W_ZERO));
    check("nop_legal", 32'(illegal_instr), 32'd0);

    // MULT then MFLO held: four stalled cycles, then MFLO goes through
    apply(6'b000000, 6'b011000, 1'b0);
    check("mult_word", 32'(word), 32'(W_MULT));
    check("mult_stall", 32'(stall_d), 32'd0);
    tick();
    apply(6'b000000, 6'b010010, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("mflo_stall%0d", i), 32'(stall_d), 32'd1);
      check($sformatf("mflo_bub%0d", i),   32'(word), 32'(W_ZERO));
      check($sformatf("mflo_busy%0d", i),  32'(mult_busy), 32'd1);
      tick();
    end
    check("mflo_nostall", 32'(stall_d), 32'd0);
    check("mflo_idle",    32'(mult_busy), 32'd0);
    check("mflo_word",    32'(word), 32'(W_MFLO));

    // Back-to-back: MULT then MULTU held; MULTU launches once after 4 stalls
    apply(6'b000000, 6'b011000, 1'b0);
    check("b2b_first", 32'(start_mult), 32'd1);
    tick();
    apply(6'b000000, 6'b011001, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b2b_stall%0d", i), 32'({stall_d, start_mult}), 32'b10);
      tick();
    end
    check("b2b_second", 32'(word), 32'(W_MULU));
    tick();
    // BUSY + LW: no stall, normal decode
    apply(6'b100011, 6'b000000, 1'b0);
    check("busy_lw_busy",  32'(mult_busy), 32'd1);
    check("busy_lw_stall", 32'(stall_d), 32'd0);
    check("busy_lw_word",  32'(word), 32'(W_LW));
    // BUSY + BEQ taken still redirects (not a hazard)
    apply(6'b000100, 6'b000000, 1'b1);
    check("busy_beq", 32'(pcsrc), 32'd1);

    // Reset during BUSY abandons the multiply
    reset = 1'b1;
    tick();
    reset = 1'b0;
    apply(6'b000000, 6'b011000, 1'b0);
    check("rmul_start", 32'(start_mult), 32'd1);
    tick();
    tick();
    reset = 1'b1;
    apply(6'b000000, 6'b011001, 1'b0);
    check("rmul_in_rst_word", 32'(word), 32'(W_ZERO));
    check("rmul_in_rst_busy", 32'(mult_busy), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("rmul_busy_drop", 32'(mult_busy), 32'd0);
    check("rmul_multu",     32'({stall_d, start_mult, mult_sign}), 32'b010);
    tick();
    check("rmul_now_busy",  32'(mult_busy), 32'd1);

    // Illegal opcode: bubble now, sticky flag from next edge until reset
    apply(6'b111111, 6'b000000, 1'b0);
    check("ill_word",   32'(word), 32'(W_ZERO));
    check("ill_before", 32'(illegal_instr), 32'd0);
    tick();
    apply(6'b000000, 6'b100000, 1'b0);
    check("ill_set",    32'(illegal_instr), 32'd1);
    check("ill_add",    32'(word), 32'(W_ADD));
    tick();
    check("ill_sticky", 32'(illegal_instr), 32'd1);
    reset = 1'b1;
    #1;
    check("ill_in_rst", 32'(illegal_instr), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("ill_cleared", 32'(illegal_instr), 32'd0);

    // Illegal R-type funct also sets the flag
    apply(6'b000000, 6'b111111, 1'b0);
    check("illr_word", 32'(word), 32'(W_ZERO));
    tick();
    apply(6'b000000, 6'b000000, 1'b0);
    check("illr_set", 32'(illegal_instr), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
